// File: rtl/add_sub.sv
// add_sub: registered WIDTH-bit ripple-carry adder/subtractor.
//
// Subtraction is A + ~B + 1. Each B bit is inverted by ctrl, and ctrl also
// feeds the carry-in of stage 0. A new operation is accepted on every cycle.
// The result and the per-stage carry-out vector are registered, so they
// appear one clock after their inputs.
//
// Ports:
//   clk   - clock; all state changes on the rising edge
//   rst   - synchronous, active-high reset; clears sum and carry
//   a     - operand A (unsigned or two's complement)
//   b     - operand B
//   ctrl  - 0: sum = A + B, 1: sum = A - B (both modulo 2^WIDTH)
//   sum   - registered result bits
//   carry - registered carry-out of each stage; carry[WIDTH-1] is the
//           overflow flag in add mode and the no-borrow flag in subtract mode
module add_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c_out;
  logic             c_in;

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;

  // Ripple chain. c_in is a procedural temporary that carries each stage's
  // carry-out into the next stage within a single evaluation.
  always_comb begin
    bx    = b ^ {WIDTH{ctrl}};
    s     = '0;
    c_out = '0;
    c_in  = ctrl;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]     = a[i] ^ bx[i] ^ c_in;
      c_out[i] = (a[i] & bx[i]) | (a[i] & c_in) | (bx[i] & c_in);
      c_in     = c_out[i];
    end
  end

  // Reset has priority over the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      sum_q   <= s;
      carry_q <= c_out;
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_add_sub.sv
// Bench for add_sub (WIDTH=4): a table of hand-computed vectors, plus short
// sequences for reset, back-to-back mode toggling and a mid-stream reset.
module tb_add_sub;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       ctrl;
  logic [3:0] sum;
  logic [3:0] carry;

  int checks;
  int errors;

  // Outputs the DUT should hold right now; used to confirm that nothing
  // changes before the clock edge.
  logic [3:0] prev_sum;
  logic [3:0] prev_carry;

  add_sub #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .ctrl (ctrl),
    .sum  (sum),
    .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       ctrl;
    logic [3:0] sum;
    logic [3:0] carry;
  } vec_t;

  vec_t vecs[12];

  // Compare sum/carry against expected values; a mask selects carry bits.
  task automatic check(input string name, input logic [3:0] exp_sum,
                       input logic [3:0] exp_carry, input logic [3:0] cmask);
    checks++;
    if (sum !== exp_sum || (carry & cmask) !== (exp_carry & cmask)) begin
      errors++;
      $display("FAIL %s: got sum=%b carry=%b, expected sum=%b carry=%b (carry mask %b)",
               name, sum, carry, exp_sum, exp_carry, cmask);
    end
  endtask

  // Drive one cycle's inputs just after an edge. Check that the outputs have
  // not moved before the next edge, then check the new result after it.
  task automatic step(input string name, input logic r, input logic [3:0] va,
                      input logic [3:0] vb, input logic vc, input logic [3:0] exp_sum,
                      input logic [3:0] exp_carry, input logic [3:0] cmask);
    rst  = r;
    a    = va;
    b    = vb;
    ctrl = vc;
    #2;
    check({name, " (pre-edge hold)"}, prev_sum, prev_carry, 4'hF);
    @(posedge clk);
    #1;
    check(name, exp_sum, exp_carry, cmask);
    prev_sum   = exp_sum;
    prev_carry = exp_carry;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{"add 1+0",     4'h1, 4'h0, 1'b0, 4'b0001, 4'b0000};
    vecs[1]  = '{"add 2+4",     4'h2, 4'h4, 1'b0, 4'b0110, 4'b0000};
    vecs[2]  = '{"add B+6",     4'hB, 4'h6, 1'b0, 4'b0001, 4'b1110};
    vecs[3]  = '{"add 5+3",     4'h5, 4'h3, 1'b0, 4'b1000, 4'b0111};
    vecs[4]  = '{"sub 1-0",     4'h1, 4'h0, 1'b1, 4'b0001, 4'b1111};
    vecs[5]  = '{"sub 2-4",     4'h2, 4'h4, 1'b1, 4'b1110, 4'b0011};
    vecs[6]  = '{"sub B-6",     4'hB, 4'h6, 1'b1, 4'b0101, 4'b1011};
    vecs[7]  = '{"sub 5-3",     4'h5, 4'h3, 1'b1, 4'b0010, 4'b1101};
    vecs[8]  = '{"add F+1 wrap", 4'hF, 4'h1, 1'b0, 4'b0000, 4'b1111};
    vecs[9]  = '{"add F+F",     4'hF, 4'hF, 1'b0, 4'b1110, 4'b1111};
    vecs[10] = '{"sub 0-1 wrap", 4'h0, 4'h1, 1'b1, 4'b1111, 4'b0000};
    vecs[11] = '{"sub 7-7",     4'h7, 4'h7, 1'b1, 4'b0000, 4'b1111};

    // Reset with all-ones operands in subtract mode must still give zeros.
    rst  = 1'b1;
    a    = 4'hF;
    b    = 4'hF;
    ctrl = 1'b1;
    @(posedge clk);
    #1;
    check("reset F,F,sub", 4'b0000, 4'b0000, 4'hF);
    prev_sum   = 4'b0000;
    prev_carry = 4'b0000;
    step("reset held", 1'b1, 4'hA, 4'h5, 1'b0, 4'b0000, 4'b0000, 4'hF);

    foreach (vecs[i]) begin
      step(vecs[i].name, 1'b0, vecs[i].a, vecs[i].b, vecs[i].ctrl,
           vecs[i].sum, vecs[i].carry, 4'hF);
    end

    // Back-to-back mode toggling with a=5, b=3.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) step("toggle add 5+3", 1'b0, 4'h5, 4'h3, 1'b0, 4'b1000, 4'b0111, 4'hF);
      else            step("toggle sub 5-3", 1'b0, 4'h5, 4'h3, 1'b1, 4'b0010, 4'b1101, 4'hF);
    end

    // Mid-stream reset: one zero cycle, then results resume.
    step("stream add B+6", 1'b0, 4'hB, 4'h6, 1'b0, 4'b0001, 4'b1110, 4'hF);
    step("stream reset",   1'b1, 4'hF, 4'hF, 1'b1, 4'b0000, 4'b0000, 4'hF);
    step("stream sub 2-4", 1'b0, 4'h2, 4'h4, 1'b1, 4'b1110, 4'b0011, 4'hF);
    step("stream add 2+4", 1'b0, 4'h2, 4'h4, 1'b0, 4'b0110, 4'b0000, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
